// File: rtl/xor_and_sched_if.sv
// Requester/consumer bundle for xor_and_sched: two operand-pair requesters
// and one tagged result channel, all valid/ready.
interface xor_and_sched_if #(
  parameter int unsigned WIDTH = 8
) ();

  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;

  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;

  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
  logic             res_id;
  logic             res_op;

  // Requesters and result consumer
  modport master (
    output req0_valid, req0_a, req0_b,
    output req1_valid, req1_a, req1_b,
    output res_ready,
    input  req0_ready, req1_ready,
    input  res_valid, res_data, res_id, res_op
  );

  // Shared logic unit
  modport slave (
    input  req0_valid, req0_a, req0_b,
    input  req1_valid, req1_a, req1_b,
    input  res_ready,
    output req0_ready, req1_ready,
    output res_valid, res_data, res_id, res_op
  );

endinterface

// File: rtl/xor_and_sched.sv
// Shared registered XOR/AND unit for two requesters: round-robin arbitration,
// per-requester op history (XOR after a zero result, AND otherwise).
module xor_and_sched #(
  parameter int unsigned WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst,
  xor_and_sched_if.slave  bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  state_e           state_q,    state_d;
  logic [WIDTH-1:0] res_data_q, res_data_d;
  logic             res_id_q,   res_id_d;
  logic             res_op_q,   res_op_d;
  logic             hist0_q,    hist0_d;
  logic             hist1_q,    hist1_d;
  logic             rr_last_q,  rr_last_d;

  logic             can_accept_c;
  logic             any_valid_c;
  logic             accept_c;
  logic             win_id_c;
  logic             win_op_c;
  logic [WIDTH-1:0] win_a_c;
  logic [WIDTH-1:0] win_b_c;
  logic [WIDTH-1:0] result_c;

  // Arbitration: a lone requester wins; on contention the one not served last wins
  always_comb begin
    win_id_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      win_id_c = ~rr_last_q;
    end else if (bus.req1_valid) begin
      win_id_c = 1'b1;
    end
  end

  assign any_valid_c  = bus.req0_valid | bus.req1_valid;
  assign can_accept_c = ((state_q == ST_EMPTY) | bus.res_ready) & ~rst;
  assign accept_c     = can_accept_c & any_valid_c;

  // Operand mux and shared logic unit
  always_comb begin
    win_a_c  = bus.req0_a;
    win_b_c  = bus.req0_b;
    win_op_c = hist0_q;
    if (win_id_c) begin
      win_a_c  = bus.req1_a;
      win_b_c  = bus.req1_b;
      win_op_c = hist1_q;
    end
    result_c = win_op_c ? (win_a_c & win_b_c) : (win_a_c ^ win_b_c);
  end

  // Output stage FSM, result payload, history and round-robin pointer
  always_comb begin
    state_d    = state_q;
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    res_op_d   = res_op_q;
    hist0_d    = hist0_q;
    hist1_d    = hist1_q;
    rr_last_d  = rr_last_q;

    if (accept_c) begin
      state_d    = ST_FULL;
      res_data_d = result_c;
      res_id_d   = win_id_c;
      res_op_d   = win_op_c;
      rr_last_d  = win_id_c;
      // History follows the issued result so back-to-back issues chain
      if (win_id_c) begin
        hist1_d = |result_c;
      end else begin
        hist0_d = |result_c;
      end
    end else if (state_q == ST_FULL && bus.res_ready) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_EMPTY;
      res_data_q <= '0;
      res_id_q   <= 1'b0;
      res_op_q   <= 1'b0;
      hist0_q    <= 1'b0;
      hist1_q    <= 1'b0;
      rr_last_q  <= 1'b1;
    end else begin
      state_q    <= state_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
      res_op_q   <= res_op_d;
      hist0_q    <= hist0_d;
      hist1_q    <= hist1_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign bus.req0_ready = accept_c & ~win_id_c;
  assign bus.req1_ready = accept_c &  win_id_c;
  assign bus.res_valid  = (state_q == ST_FULL);
  assign bus.res_data   = res_data_q;
  assign bus.res_id     = res_id_q;
  assign bus.res_op     = res_op_q;

endmodule

// File: tb/tb_xor_and_sched.sv
// Bench for xor_and_sched: directed scenarios plus randomized traffic against
// a slot-level reference model of the shared XOR/AND unit.
module tb_xor_and_sched;

  localparam int unsigned WIDTH = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  xor_and_sched_if #(.WIDTH(WIDTH)) bus ();

  xor_and_sched #(.WIDTH(WIDTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  // Reference model: one result slot, per-requester history, last winner
  logic             m_valid = 1'b0;
  logic [WIDTH-1:0] m_data  = '0;
  logic             m_id    = 1'b0;
  logic             m_op    = 1'b0;
  logic             m_hist0 = 1'b0;
  logic             m_hist1 = 1'b0;
  logic             m_rr    = 1'b1;

  function automatic logic exp_win();
    if (bus.req0_valid && bus.req1_valid) return !m_rr;
    return bus.req1_valid;
  endfunction

  // {req1_ready, req0_ready} the model grants this cycle
  function automatic logic [1:0] exp_ready();
    logic room;
    room = !rst && (!m_valid || bus.res_ready);
    if (!room || !(bus.req0_valid || bus.req1_valid)) return 2'b00;
    return exp_win() ? 2'b10 : 2'b01;
  endfunction

  task automatic tick();
    logic [1:0]       g;
    logic             w;
    logic             op;
    logic [WIDTH-1:0] a, b;
    g = exp_ready();
    w = exp_win();
    @(posedge clk);
    if (rst) begin
      m_valid = 1'b0; m_data = '0; m_id = 1'b0; m_op = 1'b0;
      m_hist0 = 1'b0; m_hist1 = 1'b0; m_rr = 1'b1;
    end else if (g != 2'b00) begin
      a  = w ? bus.req1_a : bus.req0_a;
      b  = w ? bus.req1_b : bus.req0_b;
      op = w ? m_hist1 : m_hist0;
      m_data  = op ? (a & b) : (a ^ b);
      m_id    = w;
      m_op    = op;
      m_valid = 1'b1;
      m_rr    = w;
      if (w) m_hist1 = (m_data != 0); else m_hist0 = (m_data != 0);
    end else if (bus.res_ready) begin
      m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drive(input logic v0, input logic [WIDTH-1:0] a0, input logic [WIDTH-1:0] b0,
                       input logic v1, input logic [WIDTH-1:0] a1, input logic [WIDTH-1:0] b1,
                       input logic rr);
    bus.req0_valid = v0; bus.req0_a = a0; bus.req0_b = b0;
    bus.req1_valid = v1; bus.req1_a = a1; bus.req1_b = b1;
    bus.res_ready  = rr;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", bus.res_valid); else passed++;
    checks++; if (bus.res_data !== 8'h00) $display("FAIL reset_data got %h want 00", bus.res_data); else passed++;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
      $display("FAIL reset_ready got %b want 00", {bus.req1_ready, bus.req0_ready}); else passed++;
    tick();
    checks++; if ({bus.res_valid, bus.res_id, bus.res_op} !== 3'b000)
      $display("FAIL idle_state got %b want 000", {bus.res_valid, bus.res_id, bus.res_op}); else passed++;
  endtask

  task automatic test_op_toggle();
    drive(1'b1, 8'h0F, 8'hFF, 1'b0, '0, '0, 1'b1);
    #1;
    checks++; if (bus.req0_ready !== 1'b1) $display("FAIL toggle_ready0 got %b want 1", bus.req0_ready); else passed++;
    tick();
    checks++; if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_op} !== {1'b1, 8'hF0, 1'b0, 1'b0})
      $display("FAIL toggle_r1 got v%b d%h id%b op%b want v1 dF0 id0 op0",
               bus.res_valid, bus.res_data, bus.res_id, bus.res_op); else passed++;
    tick();
    checks++; if ({bus.res_valid, bus.res_data, bus.res_op} !== {1'b1, 8'h0F, 1'b1})
      $display("FAIL toggle_r2 got v%b d%h op%b want v1 d0F op1", bus.res_valid, bus.res_data, bus.res_op); else passed++;
    drive(1'b1, 8'h0F, 8'hF0, 1'b0, '0, '0, 1'b1);
    tick();
    checks++; if ({bus.res_data, bus.res_op} !== {8'h00, 1'b1})
      $display("FAIL toggle_r3 got d%h op%b want d00 op1", bus.res_data, bus.res_op); else passed++;
    drive(1'b1, 8'h0F, 8'hFF, 1'b0, '0, '0, 1'b1);
    tick();
    checks++; if ({bus.res_data, bus.res_op} !== {8'hF0, 1'b0})
      $display("FAIL toggle_r4 got d%h op%b want dF0 op0", bus.res_data, bus.res_op); else passed++;
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    tick();
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL toggle_drain got %b want 0", bus.res_valid); else passed++;
  endtask

  task automatic test_zero_hold();
    drive(1'b0, '0, '0, 1'b1, 8'h55, 8'h55, 1'b1);
    for (int i = 0; i < 2; i++) begin
      tick();
      checks++; if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_op} !== {1'b1, 8'h00, 1'b1, 1'b0})
        $display("FAIL zero_hold_%0d got v%b d%h id%b op%b want v1 d00 id1 op0", i,
                 bus.res_valid, bus.res_data, bus.res_id, bus.res_op); else passed++;
    end
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b1);
    tick();
  endtask

  task automatic test_round_robin();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1, WIDTH'($urandom), WIDTH'($urandom), 1'b1);
      #1;
      checks++; if ({bus.req1_ready, bus.req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10))
        $display("FAIL rr_grant_%0d got %b want %b", i, {bus.req1_ready, bus.req0_ready},
                 (i % 2 == 0) ? 2'b01 : 2'b10); else passed++;
      tick();
      checks++; if ({bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, (i % 2 != 0), m_data})
        $display("FAIL rr_result_%0d got v%b id%b d%h want v1 id%b d%h", i, bus.res_valid, bus.res_id,
                 bus.res_data, (i % 2 != 0), m_data); else passed++;
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH+1:0] snap;
    drive(1'b1, 8'h3C, 8'hA5, 1'b1, 8'hC3, 8'h5A, 1'b0);
    snap = {bus.res_data, bus.res_id, bus.res_op};
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b00)
        $display("FAIL bp_ready_%0d got %b want 00", i, {bus.req1_ready, bus.req0_ready}); else passed++;
      tick();
      checks++; if ({bus.res_valid, bus.res_data, bus.res_id, bus.res_op} !== {1'b1, snap})
        $display("FAIL bp_hold_%0d got %h want %h", i, {bus.res_valid, bus.res_data, bus.res_id, bus.res_op},
                 {1'b1, snap}); else passed++;
    end
    bus.res_ready = 1'b1;
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      $display("FAIL bp_release_ready got %b want 01", {bus.req1_ready, bus.req0_ready}); else passed++;
    tick();
    checks++; if ({bus.res_valid, bus.res_id, bus.res_data} !== {1'b1, 1'b0, m_data})
      $display("FAIL bp_refill got v%b id%b d%h want v1 id0 d%h", bus.res_valid, bus.res_id,
               bus.res_data, m_data); else passed++;
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 8'h01, 8'h00, 1'b0, '0, '0, 1'b1);
    for (int i = 0; i < 3 && !(m_hist0 && m_valid); i++) tick();
    bus.res_ready  = 1'b0;
    bus.req0_valid = 1'b0;
    tick();
    checks++; if (bus.res_valid !== 1'b1) $display("FAIL mid_pending got %b want 1", bus.res_valid); else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if ({bus.res_valid, bus.res_data} !== {1'b0, 8'h00})
      $display("FAIL mid_cleared got v%b d%h want v0 d00", bus.res_valid, bus.res_data); else passed++;
    drive(1'b1, 8'h03, 8'h05, 1'b1, 8'hFF, 8'hFF, 1'b1);
    #1;
    checks++; if ({bus.req1_ready, bus.req0_ready} !== 2'b01)
      $display("FAIL mid_rr got %b want 01", {bus.req1_ready, bus.req0_ready}); else passed++;
    tick();
    checks++; if ({bus.res_data, bus.res_id, bus.res_op} !== {8'h06, 1'b0, 1'b0})
      $display("FAIL mid_xor got d%h id%b op%b want d06 id0 op0", bus.res_data, bus.res_id, bus.res_op); else passed++;
  endtask

  task automatic test_random();
    logic [WIDTH+4:0] got, want;
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 49) == 0);
      drive(1'($urandom), WIDTH'($urandom), WIDTH'($urandom),
            1'($urandom), WIDTH'($urandom_range(0, 3)), WIDTH'($urandom_range(0, 3)),
            ($urandom_range(0, 3) != 0));
      #1;
      got  = {bus.res_valid, bus.res_data, bus.res_id, bus.res_op, bus.req1_ready, bus.req0_ready};
      want = {m_valid, m_data, m_id, m_op, exp_ready()};
      checks++; if (got !== want)
        $display("FAIL random_%0d got v/d/id/op/rdy %h want %h", i, got, want); else passed++;
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    drive(1'b0, '0, '0, 1'b0, '0, '0, 1'b0);
    test_reset();
    test_op_toggle();
    test_zero_hold();
    test_round_robin();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
